serial_word_receiver: RTL

Serial-to-parallel receive end of the team's shift-register datapath: accepts a one-bit-per-strobe stream, as produced by a universal shift register running in right- or left-shift mode, and reassembles WIDTH-bit words. Completed words are presented on a valid/ready output port through a single-entry holding register. A sticky overrun flag records words lost to back-pressure.

---
 rtl/swr_pkg.sv | 12 +
 rtl/serial_word_receiver_if.sv | 33 +++
 rtl/swr_shift_core.sv | 41 ++++
 rtl/serial_word_receiver.sv | 125 ++++++++++++
 4 files changed

// File: rtl/swr_pkg.sv
// Shared types and defaults for the serial word receiver.
package swr_pkg;

    localparam int unsigned SWR_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } swr_state_t;

endpackage : swr_pkg

// File: rtl/serial_word_receiver_if.sv
// Serial-in / word-out bundle. parity_err exists only when SWR_PARITY_EN is defined.
interface serial_word_receiver_if import swr_pkg::*; #(
    parameter int unsigned WIDTH = SWR_DEFAULT_WIDTH
);
    logic             ser_in;
    logic             ser_valid;
    logic             lsb_first;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             overrun;
`ifdef SWR_PARITY_EN
    logic             parity_err;
`endif

    // Master drives the serial stream and consumes words; slave is the receiver.
    modport master (
        output ser_in, ser_valid, lsb_first, word_ready,
`ifdef SWR_PARITY_EN
        input  parity_err,
`endif
        input  word_out, word_valid, overrun
    );

    modport slave (
        input  ser_in, ser_valid, lsb_first, word_ready,
`ifdef SWR_PARITY_EN
        output parity_err,
`endif
        output word_out, word_valid, overrun
    );

endinterface : serial_word_receiver_if

// File: rtl/swr_shift_core.sv
// Direction-selectable WIDTH-bit shift register with bit counter.
module swr_shift_core import swr_pkg::*; #(
    parameter  int unsigned WIDTH = SWR_DEFAULT_WIDTH,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_shift_en,
    input  logic             i_dir,
    input  logic             i_clear,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_sreg_nxt_c,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_count;

    // Value the register takes this edge; lets the owner capture the final bit without a bubble.
    always_comb begin
        o_sreg_nxt_c = r_sreg;
        if (i_shift_en) begin
            o_sreg_nxt_c = i_dir ? {i_ser_in, r_sreg[WIDTH-1:1]}
                                 : {r_sreg[WIDTH-2:0], i_ser_in};
        end
    end

    // Clear wins over shift so the next word starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sreg  <= '0;
            r_count <= '0;
        end else if (i_shift_en) begin
            r_sreg  <= o_sreg_nxt_c;
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;

endmodule : swr_shift_core

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with single-entry holding register and sticky overrun.
// Optional trailing even-parity bit per word when SWR_PARITY_EN is defined.
module serial_word_receiver import swr_pkg::*; #(
    parameter int unsigned WIDTH = SWR_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_word_receiver_if.slave  io_bus
);

    localparam int unsigned   CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

    swr_state_t       r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_word_out;
    logic             r_word_valid;
    logic             r_overrun;
`ifdef SWR_PARITY_EN
    logic             r_parity_err;
`endif

    logic             w_shift_en;
    logic             w_dir;
    logic             w_complete;
    logic             w_last_data;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CW-1:0]    w_count;

    swr_shift_core #(.WIDTH(WIDTH)) u_core (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_shift_en   (w_shift_en),
        .i_dir        (w_dir),
        .i_clear      (w_complete),
        .i_ser_in     (io_bus.ser_in),
        .o_sreg_nxt_c (w_sreg_nxt),
        .o_count      (w_count)
    );

    assign w_last_data = io_bus.ser_valid && (w_count == LAST_DATA);

    // Core control: the direction is taken live on the first bit, then from the latch.
    always_comb begin
        w_shift_en = 1'b0;
        w_dir      = r_dir;
        w_complete = 1'b0;
        case (r_state)
            IDLE: begin
                w_shift_en = io_bus.ser_valid;
                w_dir      = io_bus.lsb_first;
            end
            SHIFT: begin
                w_shift_en = io_bus.ser_valid;
`ifndef SWR_PARITY_EN
                w_complete = w_last_data;
`endif
            end
            PARITY: begin
                w_complete = io_bus.ser_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_dir        <= 1'b0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SWR_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.ser_valid) begin
                        r_dir   <= io_bus.lsb_first;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last_data) begin
`ifdef SWR_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state <= IDLE;
`endif
                    end
                end
                PARITY: begin
                    if (io_bus.ser_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A completion may reuse the slot freed by a same-cycle handshake.
            if (w_complete) begin
                if (!r_word_valid || io_bus.word_ready) begin
                    r_word_out   <= w_sreg_nxt;
                    r_word_valid <= 1'b1;
`ifdef SWR_PARITY_EN
                    r_parity_err <= ^{w_sreg_nxt, io_bus.ser_in};
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (io_bus.word_ready) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign io_bus.word_out   = r_word_out;
    assign io_bus.word_valid = r_word_valid;
    assign io_bus.overrun    = r_overrun;
`ifdef SWR_PARITY_EN
    assign io_bus.parity_err = r_parity_err;
`endif

endmodule : serial_word_receiver
